// File: rtl/eth_rx_frame_tagger.sv
// Receive-side front stage: one-cycle AXI-Stream pass-through plus per-frame
// metadata (timestamp, length, FCS status, truncation) into a small FWFT FIFO.
module eth_rx_frame_tagger #(
    parameter int C_META_DEPTH    = 4,
    parameter int C_MAX_FRAME_LEN = 1522
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic [63:0] current_time,
    input  logic        time_running,
    input  logic        enable,
    output logic [63:0] meta_timestamp,
    output logic [15:0] meta_length,
    output logic        meta_fcs_bad,
    output logic        meta_truncated,
    output logic        meta_valid,
    input  logic        meta_ready,
    output logic [31:0] dropped_count
);

    localparam int          AW          = $clog2(C_META_DEPTH);
    localparam logic [15:0] MAX_LEN     = 16'(C_MAX_FRAME_LEN);
    localparam logic        TRUNC_FIRST = (C_MAX_FRAME_LEN < 1) ? 1'b1 : 1'b0;
    localparam logic [AW:0] PTR_ONE     = (AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_SYNC     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_IN_FRAME = 2'd2,
        ST_DISCARD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [63:0] ts;
        logic [15:0] len;
        logic        fcs_bad;
        logic        trunc;
    } meta_t;

    state_t      state_r;
    logic [63:0] ts_r;
    logic [15:0] len_r;
    logic        trunc_r;
    meta_t       mem_r [C_META_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [31:0] dropped_r;

    meta_t rec_s;
    meta_t head_s;
    logic  start_s;
    logic  at_max_s;
    logic  commit_s;
    logic  empty_s;
    logic  full_s;
    logic  pop_s;
    logic  push_s;
    logic  drop_s;

    assign start_s  = (state_r == ST_IDLE) && s_axis_tvalid && enable && time_running;
    assign at_max_s = (len_r == MAX_LEN);

    // Record as it would look if this cycle's byte closes the frame; also the next len/trunc.
    always_comb begin
        rec_s    = '0;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                rec_s.ts      = current_time;
                rec_s.len     = 16'd1;
                rec_s.fcs_bad = s_axis_tuser;
                rec_s.trunc   = TRUNC_FIRST;
                commit_s      = start_s && s_axis_tlast;
            end
            ST_IN_FRAME: begin
                rec_s.ts      = ts_r;
                rec_s.len     = at_max_s ? len_r : (len_r + 16'd1);
                rec_s.fcs_bad = s_axis_tuser;
                rec_s.trunc   = trunc_r | at_max_s;
                commit_s      = s_axis_tvalid && s_axis_tlast;
            end
            default: begin
                rec_s    = '0;
                commit_s = 1'b0;
            end
        endcase
    end

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s   = !empty_s && meta_ready;
    assign push_s  = commit_s && (!full_s || pop_s);
    assign drop_s  = commit_s && !push_s;

    // Unconditional one-cycle stream register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_axis_tdata  <= 8'd0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= s_axis_tuser;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= s_axis_tvalid;
        end
    end

    // Tagging FSM; SYNC waits out a frame already in progress when reset releases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_SYNC;
            ts_r    <= 64'd0;
            len_r   <= 16'd0;
            trunc_r <= 1'b0;
        end else begin
            case (state_r)
                ST_SYNC: begin
                    if (!s_axis_tvalid || s_axis_tlast) state_r <= ST_IDLE;
                    else                                state_r <= ST_SYNC;
                end
                ST_IDLE: begin
                    if (start_s) begin
                        ts_r    <= current_time;
                        len_r   <= 16'd1;
                        trunc_r <= TRUNC_FIRST;
                        state_r <= s_axis_tlast ? ST_IDLE : ST_IN_FRAME;
                    end else if (s_axis_tvalid && !s_axis_tlast) begin
                        state_r <= ST_DISCARD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IN_FRAME: begin
                    if (s_axis_tvalid) begin
                        len_r   <= rec_s.len;
                        trunc_r <= rec_s.trunc;
                        state_r <= s_axis_tlast ? ST_IDLE : ST_IN_FRAME;
                    end else begin
                        state_r <= ST_IN_FRAME;
                    end
                end
                ST_DISCARD: begin
                    if (s_axis_tvalid && s_axis_tlast) state_r <= ST_IDLE;
                    else                               state_r <= ST_DISCARD;
                end
                default: state_r <= ST_SYNC;
            endcase
        end
    end

    // Metadata FIFO storage, pointers and saturating drop counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < C_META_DEPTH; i++) mem_r[i] <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            dropped_r <= 32'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= rec_s;
                wr_ptr_r                <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            if (drop_s && (dropped_r != 32'hFFFF_FFFF)) dropped_r <= dropped_r + 32'd1;
        end
    end

    assign head_s         = mem_r[rd_ptr_r[AW-1:0]];
    assign meta_timestamp = head_s.ts;
    assign meta_length    = head_s.len;
    assign meta_fcs_bad   = head_s.fcs_bad;
    assign meta_truncated = head_s.trunc;
    assign meta_valid     = !empty_s;
    assign dropped_count  = dropped_r;

endmodule
